// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchroniser plus stability filter; in clk, rst_n, raw_in; out sig_clean (debounced level), busy (change being qualified)
module debounce_sync #(
   parameter int   CNT_WIDTH       = 16,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RESET_VALUE     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_in,
   output logic sig_clean,
   output logic busy
);
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   logic                 sync1;
   logic                 sync2;
   logic [CNT_WIDTH-1:0] cnt;
   assign busy = sync2 != sig_clean;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync1     <= RESET_VALUE;
         sync2     <= RESET_VALUE;
         sig_clean <= RESET_VALUE;
         cnt       <= '0;
      end else begin
         sync1     <= raw_in;
         sync2     <= sync1;
         sig_clean <= (busy && cnt == LAST) ? sync2 : sig_clean;
         cnt       <= (busy && cnt != LAST) ? cnt + 1'b1 : '0;
      end
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: window-rule model for DEBOUNCE_CYCLES=4 and =1 instances plus directed literal checks
module tb_debounce_sync;
   logic       clk;
   logic       rst_n;
   logic       raw_in;
   logic [1:0] clean_d;
   logic [1:0] busy_d;
   int         tests = 0;
   int         fails = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int D = (g == 0) ? 4 : 1;
      bit m_s1    = 1'b0;
      bit m_s2    = 1'b0;
      bit m_clean = 1'b0;
      bit hist[$];
      bit flip;
      debounce_sync #(.CNT_WIDTH(4), .DEBOUNCE_CYCLES(D), .RESET_VALUE(1'b0)) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_in   (raw_in),
         .sig_clean(clean_d[g]),
         .busy     (busy_d[g])
      );
      // inputs change just after a negedge, so at the negedge raw_in is the level the preceding posedge sampled
      initial forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            m_clean = 1'b0;
            hist = {};
         end else begin
            flip = hist.size() == D;
            foreach (hist[i]) if (hist[i] == m_clean) flip = 1'b0;
            if (flip) m_clean = !m_clean;
            m_s2 = m_s1;
            m_s1 = raw_in;
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
         end
         tests++;
         if (clean_d[g] !== m_clean || busy_d[g] !== (m_s2 != m_clean)) begin
            fails++;
            $display("FAIL model_d%0d at %0t: got clean=%b busy=%b expected clean=%b busy=%b",
                     D, $time, clean_d[g], busy_d[g], m_clean, m_s2 != m_clean);
         end
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   bit pat[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      rst_n  = 1'b0;
      raw_in = 1'b1;
      repeat (3) tick;
      check("rst_clean", clean_d[0], 1'b0);
      check("rst_busy", busy_d[0], 1'b0);
      rst_n = 1'b1;
      tick;
      check("rel_e0_busy", busy_d[0], 1'b0);
      tick;
      check("rel_e1_busy", busy_d[0], 1'b1);
      check("d1_rel_busy", busy_d[1], 1'b1);
      repeat (3) begin
         tick;
         check("rel_wait_clean", clean_d[0], 1'b0);
      end
      tick;
      check("rel_e5_clean", clean_d[0], 1'b1);
      check("rel_e5_busy", busy_d[0], 1'b0);
      raw_in = 1'b0;
      repeat (5) begin
         tick;
         check("fall_hold", clean_d[0], 1'b1);
      end
      tick;
      check("fall_e5_clean", clean_d[0], 1'b0);
      repeat (4) tick;
      raw_in = 1'b1;
      tick;
      check("step_e0_busy", busy_d[0], 1'b0);
      tick;
      check("step_e1_busy", busy_d[0], 1'b1);
      repeat (3) begin
         tick;
         check("step_wait_clean", clean_d[0], 1'b0);
      end
      tick;
      check("step_e5_clean", clean_d[0], 1'b1);
      check("step_e5_busy", busy_d[0], 1'b0);
      repeat (4) tick;
      raw_in = 1'b0;
      repeat (6) tick;
      check("back_low_clean", clean_d[0], 1'b0);
      raw_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) raw_in = 1'b0;
         tick;
         check("glitch_clean", clean_d[0], 1'b0);
         check("glitch_busy", busy_d[0], i >= 1 && i <= 3);
      end
      for (int i = 0; i < 12; i++) begin
         raw_in = (i < 7) ? pat[i] : 1'b1;
         tick;
         check("bounce_clean", clean_d[0], i >= 8);
      end
      raw_in = 1'b0;
      repeat (8) tick;
      check("pre_rst_clean", clean_d[0], 1'b0);
      raw_in = 1'b1;
      repeat (4) tick;
      check("pre_rst_busy", busy_d[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_clean", clean_d[0], 1'b0);
      check("mid_rst_busy", busy_d[0], 1'b0);
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         check("mid_rst_latency", clean_d[0], i == 5);
      end
      raw_in = 1'b0;
      repeat (8) tick;
      check("d1_pre_clean", clean_d[1], 1'b0);
      for (int t = 0; t < 4; t++) begin
         raw_in = ~raw_in;
         for (int j = 0; j < 4; j++) begin
            tick;
            check("d1_clean", clean_d[1], (j >= 2) ? raw_in : ~raw_in);
            check("d1_busy", busy_d[1], j == 1);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
